countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter SIZE, default 8, counter width in bits (legal 2..32).
REQ-002 Parameter AUTO_RELOAD, default 0, when 1 the timer reloads the last accepted value after each expiry.
REQ-003 CLK  input  1  rising-edge clock; the block's only clock.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 LOAD_VALID  input  1  load request; LOAD_VALUE is valid while high.
REQ-006 LOAD_READY  output  1  block accepts a load; a load is accepted on a rising edge with LOAD_VALID=1, LOAD_READY=1 and ABORT=0.
REQ-007 LOAD_VALUE  input  SIZE  start count.
REQ-008 ENABLE  input  1  count-down qualifier.
REQ-009 ABORT  input  1  synchronous cancel.
REQ-010 VALUE  output  SIZE  current count.
REQ-011 BUSY  output  1  high in RUN and DONE.
REQ-012 DONE  output  1  single-cycle expiry pulse.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE; LOAD_READY=1 only in IDLE, BUSY=1 in RUN and DONE, and DONE=1 only in DONE; all outputs are registered or decoded from registered state.
REQ-014 IDLE with an accepted load: VALUE<=LOAD_VALUE, the reload register <=LOAD_VALUE, next state RUN if LOAD_VALUE!=0, else DONE.
REQ-015 IDLE with LOAD_VALID=0: state and VALUE hold.
REQ-016 RUN with ENABLE=1 and VALUE>1: VALUE<=VALUE-1, stay RUN.
REQ-017 RUN with ENABLE=1 and VALUE==1: VALUE<=0, next state DONE.
REQ-018 RUN with ENABLE=0: VALUE holds.
REQ-019 VALUE SHALL never wrap below 0; the decrement is width-SIZE unsigned and no underflow occurs.
REQ-020 DONE lasts exactly one cycle.
  - AUTO_RELOAD=0: next state IDLE, VALUE stays 0.
  - AUTO_RELOAD=1: VALUE<=reload register. Next state RUN if the reload register !=0, else IDLE.
  - ENABLE is ignored in DONE.
REQ-021 ABORT=1 in any state SHALL force next state IDLE and VALUE<=0, suppress any pending DONE, and override a simultaneous LOAD_VALID (no accept).
REQ-022 Latency: a load of N>0 with ENABLE held high SHALL put DONE high in the cycle after N enabled edges from acceptance; with AUTO_RELOAD=1, DONE recurs every N+1 cycles.
REQ-023 LOAD_VALID while LOAD_READY=0 SHALL be ignored without side effects; the source holds it until accepted.

Reset
REQ-024 RESET_N low SHALL immediately and asynchronously set the state to IDLE, VALUE=0, the reload register=0, DONE=0, BUSY=0 and LOAD_READY=1, including mid-RUN or in DONE.
REQ-025 Release of RESET_N SHALL take effect on the first rising CLK edge after release, with no spurious DONE.

Structure
REQ-026 A shared package counter_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default-width constant.
REQ-027 No sub-module is required; the design is one module with an FSM, a VALUE register and a reload register.

Verification (SIZE=8)
REQ-028 Load 5, ENABLE=1 -> VALUE 5,4,3,2,1,0 on successive edges; DONE high exactly one cycle; LOAD_READY=1 the cycle after.
REQ-029 Load 3, ENABLE pattern 1,0,1,0,1 -> VALUE 2,2,1,1,0; DONE pulses once after the fifth edge.
REQ-030 Load 0 -> DONE high in the next cycle, VALUE=0, RUN never entered.
REQ-031 AUTO_RELOAD=1, load 2, ENABLE=1 -> VALUE 2,1,0,2,1,0...; DONE every 3 cycles; ABORT -> IDLE, VALUE=0.
REQ-032 Load 200, ABORT at VALUE=197 -> VALUE=0, IDLE, no DONE; LOAD_VALID with ABORT in IDLE -> not accepted.
REQ-033 RESET_N low at VALUE=4 in RUN (between edges) -> VALUE=0, BUSY=0, LOAD_READY=1 before the next edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default width.
package counter_pkg;

    localparam int unsigned DEFAULT_SIZE = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : counter_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle expiry pulse and optional auto-reload.
// A load is taken only while idle; ABORT cancels from any state and wins over a load.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int unsigned SIZE        = DEFAULT_SIZE,
    parameter int unsigned AUTO_RELOAD = 0
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            LOAD_VALID,
    output logic            LOAD_READY,
    input  logic [SIZE-1:0] LOAD_VALUE,
    input  logic            ENABLE,
    input  logic            ABORT,
    output logic [SIZE-1:0] VALUE,
    output logic            BUSY,
    output logic            DONE
);

    state_t          state, state_nxt;
    logic [SIZE-1:0] value_q, value_nxt;
    logic [SIZE-1:0] reload_q, reload_nxt;

    // State, count and reload registers; reset clears everything asynchronously.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            value_q  <= '0;
            reload_q <= '0;
        end else begin
            state    <= state_nxt;
            value_q  <= value_nxt;
            reload_q <= reload_nxt;
        end
    end

    // Next-state and next-count decode.
    always_comb begin
        state_nxt  = state;
        value_nxt  = value_q;
        reload_nxt = reload_q;
        if (ABORT) begin
            state_nxt = S_IDLE;
            value_nxt = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (LOAD_VALID) begin
                        value_nxt  = LOAD_VALUE;
                        reload_nxt = LOAD_VALUE;
                        state_nxt  = (LOAD_VALUE != '0) ? S_RUN : S_DONE;
                    end
                end
                S_RUN: begin
                    if (ENABLE) begin
                        // Reaching 1 (or a defensive 0) expires instead of decrementing,
                        // so the count can never wrap.
                        if (value_q > SIZE'(1)) begin
                            value_nxt = value_q - SIZE'(1);
                        end else begin
                            value_nxt = '0;
                            state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (AUTO_RELOAD != 0) begin
                        value_nxt = reload_q;
                        state_nxt = (reload_q != '0) ? S_RUN : S_IDLE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    value_nxt = '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        VALUE      = value_q;
        LOAD_READY = (state == S_IDLE);
        BUSY       = (state == S_RUN) || (state == S_DONE);
        DONE       = (state == S_DONE);
    end

endmodule : countdown_timer
